// File: rtl/fooart_fifo_core.sv
// 16550-compatible host port: RX/TX FIFOs, paced TX drain, prioritised IIR interrupts,
// RX overrun flag, FCR flush/trigger control and MCR loopback.
module fooart_fifo_core #(
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int DRAIN_DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cs,
  input  logic [2:0] i_addr,
  input  logic       i_rd,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic [7:0] i_rx,
  input  logic       i_rx_stb,
  output logic [7:0] o_tx,
  output logic       o_tx_stb,
  output logic       o_int
);

  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int DCW  = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  localparam logic [RXAW:0]    RX_FULL_CNT = (RXAW+1)'(RX_DEPTH);
  localparam logic [TXAW:0]    TX_FULL_CNT = (TXAW+1)'(TX_DEPTH);
  localparam logic [DCW-1:0]   DRAIN_LOAD  = DCW'(DRAIN_DIV - 1);
  localparam logic [RXAW:0]    TRIG_1  = (RXAW+1)'(1);
  localparam logic [RXAW:0]    TRIG_4  = (RXAW+1)'(4);
  localparam logic [RXAW:0]    TRIG_8  = (RXAW+1)'((RX_DEPTH < 8) ? RX_DEPTH : 8);
  localparam logic [RXAW:0]    TRIG_14 = (RXAW+1)'((RX_DEPTH < 14) ? RX_DEPTH : 14);

  // Bus edge detection and control registers
  logic           prev_rd_q, prev_wr_q;
  logic [7:0]     lcr_q, lcr_d, scr_q, scr_d, dll_q, dll_d, dlm_q, dlm_d;
  logic [3:0]     ier_q, ier_d;
  logic [4:0]     mcr_q, mcr_d;
  logic [1:0]     trig_sel_q, trig_sel_d;
  logic           oe_q, oe_d, thre_pend_q, thre_pend_d;
  logic           int_q;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_stb_q, tx_stb_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  // FIFO storage and pointers
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [RXAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RXAW:0]   rx_cnt_q, rx_cnt_d;
  logic [TXAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TXAW:0]   tx_cnt_q, tx_cnt_d;

  logic       rd_go_s, wr_go_s, dlab_s, loop_s;
  logic       rbr_rd_s, thr_wr_s, iir_rd_s, fcr_wr_s, lsr_rd_s, ier_wr_s;
  logic       rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic       rx_flush_s, tx_flush_s, rx_pop_s, rx_req_s, rx_push_s, rx_ovr_s;
  logic       tx_pop_s, tx_push_s;
  logic [7:0] rx_wdata_s, tx_head_s, rbr_s, lsr_s;
  logic [RXAW:0] trig_lvl_s;
  logic [3:0] int_id_s;

  assign rd_go_s  = i_cs & i_rd & ~prev_rd_q;
  assign wr_go_s  = i_cs & i_wr & ~prev_wr_q;
  assign dlab_s   = lcr_q[7];
  assign loop_s   = mcr_q[4];

  assign rbr_rd_s = rd_go_s & (i_addr == 3'd0) & ~dlab_s;
  assign thr_wr_s = wr_go_s & (i_addr == 3'd0) & ~dlab_s;
  assign ier_wr_s = wr_go_s & (i_addr == 3'd1) & ~dlab_s;
  assign iir_rd_s = rd_go_s & (i_addr == 3'd2);
  assign fcr_wr_s = wr_go_s & (i_addr == 3'd2);
  assign lsr_rd_s = rd_go_s & (i_addr == 3'd5);

  assign rx_empty_s = (rx_cnt_q == '0);
  assign rx_full_s  = (rx_cnt_q == RX_FULL_CNT);
  assign tx_empty_s = (tx_cnt_q == '0);
  assign tx_full_s  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_head_s  = tx_mem_q[tx_rp_q];
  assign rbr_s      = rx_empty_s ? 8'h00 : rx_mem_q[rx_rp_q];

  assign tx_flush_s = fcr_wr_s & i_data[2];
  assign tx_pop_s   = ~tx_empty_s & (drain_cnt_q == '0) & ~tx_flush_s;
  assign tx_push_s  = thr_wr_s & (~tx_full_s | tx_pop_s) & ~tx_flush_s;

  // In loopback the drained byte replaces the host as the only RX source
  assign rx_flush_s = fcr_wr_s & i_data[1];
  assign rx_req_s   = loop_s ? tx_pop_s  : i_rx_stb;
  assign rx_wdata_s = loop_s ? tx_head_s : i_rx;
  assign rx_pop_s   = rbr_rd_s & ~rx_empty_s & ~rx_flush_s;
  assign rx_push_s  = rx_req_s & (~rx_full_s | rx_pop_s) & ~rx_flush_s;
  assign rx_ovr_s   = rx_req_s & rx_full_s & ~rx_pop_s & ~rx_flush_s;

  assign lsr_s = {1'b0, tx_empty_s & (drain_cnt_q == '0), tx_empty_s, 3'b000, oe_q, ~rx_empty_s};

  // FIFO pointer and occupancy next-state
  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (rx_flush_s) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push_s) rx_wp_d = rx_wp_q + RXAW'(1);
      else           rx_wp_d = rx_wp_q;
      if (rx_pop_s)  rx_rp_d = rx_rp_q + RXAW'(1);
      else           rx_rp_d = rx_rp_q;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_d = rx_cnt_q + (RXAW+1)'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - (RXAW+1)'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
    if (tx_flush_s) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push_s) tx_wp_d = tx_wp_q + TXAW'(1);
      else           tx_wp_d = tx_wp_q;
      if (tx_pop_s)  tx_rp_d = tx_rp_q + TXAW'(1);
      else           tx_rp_d = tx_rp_q;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_d = tx_cnt_q + (TXAW+1)'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - (TXAW+1)'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // RX trigger level and interrupt priority encoder
  always_comb begin
    case (trig_sel_q)
      2'd0:    trig_lvl_s = TRIG_1;
      2'd1:    trig_lvl_s = TRIG_4;
      2'd2:    trig_lvl_s = TRIG_8;
      default: trig_lvl_s = TRIG_14;
    endcase
    if (ier_q[2] & oe_q)                           int_id_s = 4'b0110;
    else if (ier_q[0] & (rx_cnt_q >= trig_lvl_s))  int_id_s = 4'b0100;
    else if (ier_q[1] & thre_pend_q)               int_id_s = 4'b0010;
    else                                           int_id_s = 4'b0001;
  end

  // Register writes, status flags, drain pacing and output strobes
  always_comb begin
    lcr_d = lcr_q; ier_d = ier_q; mcr_d = mcr_q; scr_d = scr_q;
    dll_d = dll_q; dlm_d = dlm_q; trig_sel_d = trig_sel_q;
    if (wr_go_s) begin
      case (i_addr)
        3'd0:    if (dlab_s) dll_d = i_data; else dll_d = dll_q;
        3'd1:    if (dlab_s) dlm_d = i_data; else ier_d = i_data[3:0];
        3'd2:    trig_sel_d = i_data[7:6];
        3'd3:    lcr_d = i_data;
        3'd4:    mcr_d = i_data[4:0];
        3'd7:    scr_d = i_data;
        default: lcr_d = lcr_q;
      endcase
    end else begin
      lcr_d = lcr_q;
    end

    if (rx_ovr_s)      oe_d = 1'b1;
    else if (lsr_rd_s) oe_d = 1'b0;
    else               oe_d = oe_q;

    // A new THRE event wins over a simultaneous acknowledge
    if ((~tx_empty_s & (tx_cnt_d == '0)) | (ier_wr_s & i_data[1] & ~ier_q[1] & tx_empty_s))
      thre_pend_d = 1'b1;
    else if ((iir_rd_s & (int_id_s == 4'b0010)) | thr_wr_s)
      thre_pend_d = 1'b0;
    else
      thre_pend_d = thre_pend_q;

    if (tx_flush_s)              drain_cnt_d = '0;
    else if (tx_pop_s)           drain_cnt_d = DRAIN_LOAD;
    else if (drain_cnt_q != '0)  drain_cnt_d = drain_cnt_q - DCW'(1);
    else                         drain_cnt_d = drain_cnt_q;

    tx_stb_d = tx_pop_s & ~loop_s;
    if (tx_stb_d) tx_byte_d = tx_head_s;
    else          tx_byte_d = tx_byte_q;
  end

  // Sequential state with asynchronous reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_rd_q   <= 1'b0;
      prev_wr_q   <= 1'b0;
      lcr_q       <= 8'h03;
      ier_q       <= 4'h0;
      mcr_q       <= 5'h00;
      scr_q       <= 8'h00;
      dll_q       <= 8'h00;
      dlm_q       <= 8'h00;
      trig_sel_q  <= 2'd0;
      oe_q        <= 1'b0;
      thre_pend_q <= 1'b0;
      int_q       <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_stb_q    <= 1'b0;
      drain_cnt_q <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      rx_cnt_q    <= '0;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_cnt_q    <= '0;
    end else begin
      prev_rd_q   <= i_cs & i_rd;
      prev_wr_q   <= i_cs & i_wr;
      lcr_q       <= lcr_d;
      ier_q       <= ier_d;
      mcr_q       <= mcr_d;
      scr_q       <= scr_d;
      dll_q       <= dll_d;
      dlm_q       <= dlm_d;
      trig_sel_q  <= trig_sel_d;
      oe_q        <= oe_d;
      thre_pend_q <= thre_pend_d;
      int_q       <= (int_id_s != 4'b0001);
      tx_byte_q   <= tx_byte_d;
      tx_stb_q    <= tx_stb_d;
      drain_cnt_q <= drain_cnt_d;
      rx_wp_q     <= rx_wp_d;
      rx_rp_q     <= rx_rp_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  // FIFO storage; occupancy counters guard every read so contents need no reset
  always_ff @(posedge i_clk) begin
    if (rx_push_s) rx_mem_q[rx_wp_q] <= rx_wdata_s;
    if (tx_push_s) tx_mem_q[tx_wp_q] <= i_data;
  end

  // Combinational read mux
  always_comb begin
    o_data = 8'h00;
    if (i_cs & i_rd) begin
      case (i_addr)
        3'd0:    o_data = dlab_s ? dll_q : rbr_s;
        3'd1:    o_data = dlab_s ? dlm_q : {4'h0, ier_q};
        3'd2:    o_data = {2'b11, 2'b00, int_id_s};
        3'd3:    o_data = lcr_q;
        3'd4:    o_data = {3'b000, mcr_q};
        3'd5:    o_data = lsr_s;
        3'd7:    o_data = scr_q;
        default: o_data = 8'h00;
      endcase
    end else begin
      o_data = 8'h00;
    end
  end

  assign o_tx     = tx_byte_q;
  assign o_tx_stb = tx_stb_q;
  assign o_int    = int_q;

endmodule

// File: tb/tb_fooart_fifo_core.sv
// Directed self-checking bench for fooart_fifo_core (RX_DEPTH=16, TX_DEPTH=16, DRAIN_DIV=4).
module tb_fooart_fifo_core;

  logic       clk = 1'b0;
  logic       rst_n, cs, rd, wr, rx_stb;
  logic [2:0] addr;
  logic [7:0] wdata, rdata, rx, tx;
  logic       tx_stb, irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] tx_log[$];
  int         tx_cyc[$];

  always #5 clk = ~clk;

  fooart_fifo_core #(.RX_DEPTH(16), .TX_DEPTH(16), .DRAIN_DIV(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_addr(addr), .i_rd(rd), .i_wr(wr),
    .i_data(wdata), .o_data(rdata), .i_rx(rx), .i_rx_stb(rx_stb),
    .o_tx(tx), .o_tx_stb(tx_stb), .o_int(irq)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_stb === 1'b1) begin
      tx_log.push_back(tx);
      tx_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0; cs = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = rdata;
    tick();
    rd = 1'b0; cs = 1'b0;
    tick();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx = b; rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 8'h00;
    rx = 8'h00; rx_stb = 1'b0;
    repeat (3) tick();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", irq); end
    n_tests++; if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL reset_tx_stb: got %b expected 0", tx_stb); end
    n_tests++; if (tx !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got %h expected 00", tx); end
    rst_n = 1'b1;
    tick();
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL idle_data: got %h expected 00", rdata); end
    bus_read(3'd2, d);
    n_tests++; if (d !== 8'hC1) begin n_fail++; $display("FAIL reset_iir: got %h expected C1", d); end
    bus_read(3'd3, d);
    n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL reset_lcr: got %h expected 03", d); end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h60) begin n_fail++; $display("FAIL reset_lsr: got %h expected 60", d); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_int2: got %b expected 0", irq); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    bus_write(3'd3, 8'h83);
    bus_write(3'd0, 8'h12);
    bus_write(3'd1, 8'h34);
    bus_read(3'd0, d);
    n_tests++; if (d !== 8'h12) begin n_fail++; $display("FAIL dll: got %h expected 12", d); end
    bus_read(3'd1, d);
    n_tests++; if (d !== 8'h34) begin n_fail++; $display("FAIL dlm: got %h expected 34", d); end
    bus_write(3'd3, 8'h03);
    bus_write(3'd7, 8'hA5);
    bus_read(3'd7, d);
    n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL scr: got %h expected A5", d); end
    bus_read(3'd6, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL msr: got %h expected 00", d); end
    bus_write(3'd1, 8'hF8);
    bus_read(3'd1, d);
    n_tests++; if (d !== 8'h08) begin n_fail++; $display("FAIL ier_mask: got %h expected 08", d); end
    bus_write(3'd1, 8'h00);
    bus_write(3'd4, 8'hEF);
    bus_read(3'd4, d);
    n_tests++; if (d !== 8'h0F) begin n_fail++; $display("FAIL mcr_mask: got %h expected 0F", d); end
    bus_write(3'd4, 8'h00);
  endtask

  task automatic test_tx_drain();
    logic [7:0] d;
    int base;
    base = tx_log.size();
    bus_write(3'd0, 8'h41);
    bus_write(3'd0, 8'h42);
    bus_write(3'd0, 8'h43);
    for (int i = 0; i < 40 && tx_log.size() < base + 3; i++) tick();
    n_tests++; if (tx_log.size() !== base + 3) begin n_fail++; $display("FAIL drain_count: got %0d expected %0d", tx_log.size() - base, 3); end
    if (tx_log.size() >= base + 3) begin
      n_tests++; if (tx_log[base] !== 8'h41) begin n_fail++; $display("FAIL drain_b0: got %h expected 41", tx_log[base]); end
      n_tests++; if (tx_log[base+1] !== 8'h42) begin n_fail++; $display("FAIL drain_b1: got %h expected 42", tx_log[base+1]); end
      n_tests++; if (tx_log[base+2] !== 8'h43) begin n_fail++; $display("FAIL drain_b2: got %h expected 43", tx_log[base+2]); end
      n_tests++; if (tx_cyc[base+1] - tx_cyc[base] !== 4) begin n_fail++; $display("FAIL drain_gap0: got %0d expected 4", tx_cyc[base+1] - tx_cyc[base]); end
      n_tests++; if (tx_cyc[base+2] - tx_cyc[base+1] !== 4) begin n_fail++; $display("FAIL drain_gap1: got %0d expected 4", tx_cyc[base+2] - tx_cyc[base+1]); end
    end
    repeat (6) tick();
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h60) begin n_fail++; $display("FAIL drain_temt: got %h expected 60", d); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] d;
    for (int k = 0; k < 17; k++) rx_push(8'(k));
    bus_write(3'd1, 8'h04);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oe_int: got %b expected 1", irq); end
    bus_read(3'd2, d);
    n_tests++; if (d !== 8'hC6) begin n_fail++; $display("FAIL oe_iir: got %h expected C6", d); end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h63) begin n_fail++; $display("FAIL oe_lsr1: got %h expected 63", d); end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h61) begin n_fail++; $display("FAIL oe_lsr2: got %h expected 61", d); end
    for (int k = 0; k < 16; k++) begin
      bus_read(3'd0, d);
      n_tests++; if (d !== 8'(k)) begin n_fail++; $display("FAIL rbr_%0d: got %h expected %h", k, d, 8'(k)); end
    end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h60) begin n_fail++; $display("FAIL rx_drained_lsr: got %h expected 60", d); end
    bus_write(3'd1, 8'h00);
  endtask

  task automatic test_trigger();
    logic [7:0] d;
    bus_write(3'd2, 8'h40);
    bus_write(3'd1, 8'h01);
    rx_push(8'hA0);
    rx_push(8'hA1);
    rx_push(8'hA2);
    tick(); tick();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL trig_below: got %b expected 0", irq); end
    rx_push(8'hA3);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL trig_lag: got %b expected 0", irq); end
    tick();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL trig_int: got %b expected 1", irq); end
    bus_read(3'd2, d);
    n_tests++; if (d !== 8'hC4) begin n_fail++; $display("FAIL trig_iir: got %h expected C4", d); end
    bus_read(3'd0, d);
    n_tests++; if (d !== 8'hA0) begin n_fail++; $display("FAIL trig_rbr: got %h expected A0", d); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL trig_clear: got %b expected 0", irq); end
    bus_write(3'd1, 8'h00);
    bus_write(3'd2, 8'h06);
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h60) begin n_fail++; $display("FAIL flush_lsr: got %h expected 60", d); end
  endtask

  task automatic test_thre();
    logic [7:0] d;
    int base;
    bus_write(3'd1, 8'h02);
    bus_read(3'd2, d);
    n_tests++; if (d !== 8'hC2) begin n_fail++; $display("FAIL thre_iir: got %h expected C2", d); end
    bus_read(3'd2, d);
    n_tests++; if (d !== 8'hC1) begin n_fail++; $display("FAIL thre_ack: got %h expected C1", d); end
    base = tx_log.size();
    bus_write(3'd0, 8'h77);
    repeat (4) tick();
    bus_read(3'd2, d);
    n_tests++; if (d !== 8'hC2) begin n_fail++; $display("FAIL thre_again: got %h expected C2", d); end
    n_tests++; if (tx_log.size() !== base + 1) begin n_fail++; $display("FAIL thre_tx_count: got %0d expected 1", tx_log.size() - base); end
    if (tx_log.size() == base + 1) begin
      n_tests++; if (tx_log[base] !== 8'h77) begin n_fail++; $display("FAIL thre_tx_byte: got %h expected 77", tx_log[base]); end
    end
    bus_write(3'd1, 8'h00);
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    int base;
    base = tx_log.size();
    bus_write(3'd4, 8'h10);
    bus_write(3'd0, 8'h5A);
    bus_write(3'd0, 8'h5B);
    repeat (12) tick();
    n_tests++; if (tx_log.size() !== base) begin n_fail++; $display("FAIL loop_no_stb: got %0d strobes expected 0", tx_log.size() - base); end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h61) begin n_fail++; $display("FAIL loop_lsr: got %h expected 61", d); end
    cs = 1'b1; rd = 1'b1; addr = 3'd0;
    #1;
    d = rdata;
    n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL loop_rbr: got %h expected 5A", d); end
    repeat (3) tick();
    rd = 1'b0; cs = 1'b0;
    tick();
    bus_read(3'd0, d);
    n_tests++; if (d !== 8'h5B) begin n_fail++; $display("FAIL loop_single_pop: got %h expected 5B", d); end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h60) begin n_fail++; $display("FAIL loop_empty: got %h expected 60", d); end
    bus_write(3'd4, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int base;
    bus_write(3'd3, 8'h1B);
    bus_write(3'd0, 8'h11);
    bus_write(3'd0, 8'h22);
    bus_write(3'd0, 8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stb: got %b expected 0", tx_stb); end
    tick(); tick();
    rst_n = 1'b1;
    base = tx_log.size();
    repeat (10) tick();
    n_tests++; if (tx_log.size() !== base) begin n_fail++; $display("FAIL mid_reset_discard: got %0d strobes expected 0", tx_log.size() - base); end
    bus_read(3'd5, d);
    n_tests++; if (d !== 8'h60) begin n_fail++; $display("FAIL mid_reset_lsr: got %h expected 60", d); end
    bus_read(3'd3, d);
    n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL mid_reset_lcr: got %h expected 03", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_drain();
    test_rx_overrun();
    test_trigger();
    test_thre();
    test_loopback();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fooart_fifo_core.md
Name: fooart_fifo_core

Overview:
- Next-generation simulator host port, register-compatible with a 16550 as software sees it.
- Adds parametrised RX/TX FIFOs, a paced TX drain to the host, a working IER/IIR interrupt scheme with priorities, RX overrun detection, FCR FIFO control and MCR loopback.
- Sits on the CPU I/O bus in place of the simulator-only port; the host simulator pushes RX bytes and captures TX bytes.

Parameters:
- RX_DEPTH, 16: RX FIFO entries; power of two, at least 4.
- TX_DEPTH, 16: TX FIFO entries; power of two, at least 4.
- DRAIN_DIV, 16: minimum clock cycles between successive TX bytes to the host; must be 1 or more.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_cs  in  1  chip select.
- i_addr  in  3  register address.
- i_rd  in  1  read strobe; may span multiple cycles.
- i_wr  in  1  write strobe; may span multiple cycles.
- i_data  in  8  write data.
- o_data  out  8  read data; combinational, 8'h00 when not (i_cs & i_rd).
- i_rx  in  8  host RX byte.
- i_rx_stb  in  1  one-cycle pulse: push i_rx into the RX FIFO.
- o_tx  out  8  TX byte to the host; valid while o_tx_stb=1.
- o_tx_stb  out  1  one-cycle pulse: host captures o_tx.
- o_int  out  1  interrupt request, active high.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - Both FIFOs empty; all registers 0 except LCR=8'h03 and drain counter=0.
  - o_tx_stb=0, o_tx=8'h00, o_int=0.
  - IIR reads 8'hC1.
- Access qualification:
  - rd_go = i_cs & i_rd & ~prev_rd and wr_go = i_cs & i_wr & ~prev_wr, where prev_* is the registered previous (i_cs & i_*).
  - All side effects (pop, push, clear) occur only on the rd_go / wr_go cycle.
  - A multi-cycle strobe acts exactly once.
- Register map (DLAB = LCR[7]):
  - 0, DLAB=0: read RBR = RX head (8'h00 if empty), pop on rd_go. Write THR = push to TX FIFO; dropped if full, with no error flag.
  - 0, DLAB=1: DLL read/write.
  - 1, DLAB=0: IER read/write, bits [3:0]; bits [7:4] read 0.
  - 1, DLAB=1: DLM read/write.
  - 2: read IIR = {2'b11, 2'b00, id[3:0]}. Write FCR:
    - bit1: flush RX FIFO.
    - bit2: flush TX FIFO and reset the drain counter.
    - bits[7:6]: RX trigger level 1/4/8/14; each level is clamped to RX_DEPTH, and the value is stored.
  - 3: LCR read/write.
  - 4: MCR read/write, bits [4:0]. MCR[4] = loopback.
  - 5: LSR, read-only:
    - bit0 DR = RX not empty.
    - bit1 OE.
    - bit5 THRE = TX FIFO empty.
    - bit6 TEMT = TX empty and drain counter 0.
    - All other bits 0.
    - rd_go on LSR clears OE on the following cycle; the value read shows OE still set.
  - 6: MSR reads 8'h00.
  - 7: SCR read/write.
- RX path:
  - i_rx_stb with the FIFO not full pushes i_rx.
  - i_rx_stb with the FIFO full drops the byte and sets OE.
  - Push and pop in the same cycle with the FIFO full: pop first, then push succeeds, no OE.
  - Push and pop in the same cycle with the FIFO empty: the pop returns 8'h00, the push succeeds, and the count becomes 1.
- TX drain:
  - When the TX FIFO is not empty and the drain counter is 0, the head byte is popped on the next edge. o_tx = byte and o_tx_stb = 1 for exactly that one cycle.
  - On each pop the counter loads DRAIN_DIV-1, then decrements to 0.
  - A THR push into a full FIFO in the same cycle as a drain pop is accepted.
- Loopback (MCR[4]=1): the drained byte is pushed into the RX FIFO (overrun rules apply) instead of being sent; o_tx_stb stays 0.
- Interrupt identification, highest priority first:
  - 4'b0110: IER[2] & OE. Cleared by the LSR read.
  - 4'b0100: IER[0] & RX count >= trigger level.
  - 4'b0010: IER[1] & thre_pend. Cleared by rd_go on IIR when it is the reported id, or by a THR write.
  - 4'b0001: none of the above.
- thre_pend:
  - Set on the cycle the TX FIFO becomes empty.
  - Also set on an IER[1] 0→1 write while the FIFO is empty.
- o_int = (id != 4'b0001), registered, so it lags its cause by one cycle.
- Reset mid-operation: immediately returns everything to the reset values; FIFO contents are discarded and any pending o_tx_stb is cancelled.

Test Plan:
- Reset, then read addr 2, 3 and 5 → 8'hC1, 8'h03 and 8'h60. o_int=0.
- DRAIN_DIV=4: write THR 8'h41, 8'h42, 8'h43 back-to-back → o_tx_stb pulses 4 cycles apart carrying 41, 42, 43. LSR bit6 = 1 after the last pulse.
- RX_DEPTH=16: 17 i_rx_stb pulses of 0x00..0x10 → LSR = 8'h63 and IIR id = 6 with IER=4. The LSR read returns bit1=1; the next read has bit1=0. 16 RBR reads return 0x00..0x0F.
- FCR = 8'h40 (trigger 4), IER = 1: push 3 bytes → o_int=0. Push a 4th byte → o_int=1 one cycle later, IIR = 8'hC4. One RBR read → o_int=0.
- IER = 2 with TX empty → IIR = 8'hC2. Reading IIR clears it → 8'hC1. A THR write followed by the drain → IIR returns to 8'hC2.
- MCR = 8'h10, write THR 8'h5A → no o_tx_stb, LSR bit0=1, RBR = 8'h5A. A 3-cycle i_rd strobe pops exactly once.
